recir_lanes: RTL and testbench
==============================

# recir_lanes

Parametrised multi-lane recirculation stage with a configurable register pipeline. Each cycle it captures up to LANES words with per-lane valids and routes them, after PIPE_DEPTH cycles, either forward to the next block (`active`=1) or back to the source on the return path (`active`=0). Mode changes take effect only at a transfer boundary, so a multi-cycle burst is never split between paths. It is the single-clock, N-lane successor to the two-lane Flops/Recirculation pair and sits between the byte-striping stage and the PHY side.

## Interface
- `LANES`, 4, number of parallel lanes (1..8)
- `DATA_W`, 32, bits per lane word
- `PIPE_DEPTH`, 2, register stages from input to output (1..4); the last stage is the output register
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `active`  in  1  requested mode: 1 = forward, 0 = recirculate
- `valid_in`  in  LANES  per-lane input valid
- `data_in`  in  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]
- `valid_out`  out  LANES  forward-path valid
- `data_out`  out  LANES*DATA_W  forward-path data
- `valid_ret`  out  LANES  return-path valid
- `data_ret`  out  LANES*DATA_W  return-path data
- `mode_fwd`  out  1  1 when FSM is in FWD or FWD2RECIR
- `fwd_cnt`  out  16  forwarded-transfer count (see Configuration)
- `ret_cnt`  out  16  recirculated-transfer count (see Configuration)

## Operation
- FSM states: RECIR (reset state), RECIR2FWD, FWD, FWD2RECIR.
- RECIR: `active`=1 -> RECIR2FWD if any `valid_in` bit is 1, else directly FWD.
- RECIR2FWD: routes as RECIR; on first cycle with `valid_in`==0 -> FWD; if `active` returns to 0 first -> RECIR.
- FWD / FWD2RECIR: symmetric to the above.
- Route tag: each captured word carries the route bit from the state at capture (1 only in FWD/FWD2RECIR). The tag travels with the data, so words already in flight finish on their original path.
- Output stage: tag=1 drives `valid_out`/`data_out` and holds the return path at zero; tag=0 does the opposite.
- A lane whose valid is 0 drives all-zero data on both paths. Data is never left stale.
- Lanes are independent in data but share the route tag and FSM.
- A "transfer" is an output cycle with any valid bit set on that path.

## Timing
- Latency: a word sampled at rising edge N appears on its path after edge N+PIPE_DEPTH-1, i.e. it is visible for the cycle following the PIPE_DEPTH-th edge. Throughput: one word per lane per cycle, with no stalls or backpressure.
- The FSM transition and the capture of that cycle's inputs happen on the same edge. A capture always uses the pre-edge state.
- Reset (any time, including mid-burst): all pipeline stages, valids, data, counters cleared to 0; FSM = RECIR; `mode_fwd`=0. In-flight words are discarded. Outputs go to zero asynchronously.
- First capture after reset deassert happens on the first rising edge with `reset`=0.
- `active` toggling every cycle during continuous valid traffic keeps the FSM in its current stable state or bouncing through its pending state. No word ever changes path.

## Configuration
- `RECIR_CNT_EN` defined: `fwd_cnt` and `ret_cnt` increment by 1 per transfer on their path, measured at the output stage. They saturate at 16'hFFFF and are cleared only by reset.
- `RECIR_CNT_EN` undefined: counter logic is not compiled; both ports are tied to 16'h0000.

## Test plan
1. Reset check: `reset`=1 for 3 cycles with random inputs. All outputs are 0, `mode_fwd`=0, and outputs drop to 0 asynchronously when `reset` is asserted mid-cycle.
2. Recirculate: `active`=0, `valid_in`=4'b1111, lane i data = 32'h0000ABCD*(i+1) for 4 cycles. With PIPE_DEPTH=2, the same words appear on `data_ret` 2 edges later, `valid_out`=0, and `ret_cnt`=4 (macro on).
3. Boundary switch: continuous `valid_in`=4'b0101 with `active` raised in cycle 2, then `valid_in`=0 in cycle 5. FSM goes RECIR2FWD and then FWD on the cycle-5 edge; words from cycles 0–4 exit on the return path and later words on the forward path.
4. Idle switch: `valid_in`=0 and `active` rises. FWD is reached after 1 edge and `mode_fwd`=1. A word 32'h0000EFAB on lane 3 in the next cycle exits on `data_out` only.
5. Abort pending: in FWD2RECIR, `active` returns to 1 before any idle cycle. FSM is back in FWD, and all words stay on the forward path.
6. Counter saturation (macro on): 70000 forwarded transfers give `fwd_cnt`=16'hFFFF with no wrap. With the macro off, both counters stay 0 throughout.

Source files
------------

// File: rtl/recir_lanes.sv
// recir_lanes: N-lane recirculation stage with a PIPE_DEPTH register pipeline.
// Words are tagged with a route bit at capture (forward or return path) and
// the tag travels with them, so mode changes never re-route in-flight data.
// The FSM defers mode changes to a transfer boundary (first idle input cycle).
// Optional feature macro: RECIR_CNT_EN enables the saturating per-path
// transfer counters; when undefined, fwd_cnt/ret_cnt are tied to zero.

// One lane of the data pipeline plus the output steering for that lane.
module recir_lanes_lane #(
    parameter int DATA_W     = 32,
    parameter int PIPE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              tag_i,      // route tag of the output stage
    output logic              vld_fwd_o,
    output logic [DATA_W-1:0] dat_fwd_o,
    output logic              vld_ret_o,
    output logic [DATA_W-1:0] dat_ret_o
);
    logic [PIPE_DEPTH-1:0]             vld_pipe_q;
    logic [PIPE_DEPTH-1:0][DATA_W-1:0] dat_pipe_q;

    // Capture and shift; invalid words are zeroed on entry so nothing stale leaks out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= vld_i;
            dat_pipe_q[0] <= vld_i ? dat_i : '0;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                vld_pipe_q[s] <= vld_pipe_q[s-1];
                dat_pipe_q[s] <= dat_pipe_q[s-1];
            end
        end
    end

    logic              vld_last;
    logic [DATA_W-1:0] dat_last;
    assign vld_last = vld_pipe_q[PIPE_DEPTH-1];
    assign dat_last = dat_pipe_q[PIPE_DEPTH-1];

    // Steer the output stage to exactly one path; the other path sits at zero.
    assign vld_fwd_o = tag_i & vld_last;
    assign vld_ret_o = ~tag_i & vld_last;
    assign dat_fwd_o = vld_fwd_o ? dat_last : '0;
    assign dat_ret_o = vld_ret_o ? dat_last : '0;
endmodule

module recir_lanes #(
    parameter int LANES      = 4,
    parameter int DATA_W     = 32,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    active,
    input  logic [LANES-1:0]        valid_in,
    input  logic [LANES*DATA_W-1:0] data_in,
    output logic [LANES-1:0]        valid_out,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic [LANES-1:0]        valid_ret,
    output logic [LANES*DATA_W-1:0] data_ret,
    output logic                    mode_fwd,
    output logic [15:0]             fwd_cnt,
    output logic [15:0]             ret_cnt
);
    typedef enum logic [1:0] {
        RECIR     = 2'd0,
        RECIR2FWD = 2'd1,
        FWD       = 2'd2,
        FWD2RECIR = 2'd3
    } state_t;

    state_t                state_q;
    logic                  mode_fwd_q;   // registered route: 1 in FWD / FWD2RECIR
    logic [PIPE_DEPTH-1:0] tag_q;
    logic                  any_vld;

    assign any_vld  = |valid_in;
    assign mode_fwd = mode_fwd_q;

    // Mode FSM: a requested switch waits in a pending state until an idle input
    // cycle, and a request that is withdrawn first returns to the stable state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RECIR;
            mode_fwd_q <= 1'b0;
        end else begin
            case (state_q)
                RECIR: begin
                    if (active) begin
                        if (any_vld) begin
                            state_q <= RECIR2FWD;
                        end else begin
                            state_q    <= FWD;
                            mode_fwd_q <= 1'b1;
                        end
                    end
                end
                RECIR2FWD: begin
                    if (!active) begin
                        state_q <= RECIR;
                    end else if (!any_vld) begin
                        state_q    <= FWD;
                        mode_fwd_q <= 1'b1;
                    end
                end
                FWD: begin
                    if (!active) begin
                        if (any_vld) begin
                            state_q <= FWD2RECIR;
                        end else begin
                            state_q    <= RECIR;
                            mode_fwd_q <= 1'b0;
                        end
                    end
                end
                FWD2RECIR: begin
                    if (active) begin
                        state_q <= FWD;
                    end else if (!any_vld) begin
                        state_q    <= RECIR;
                        mode_fwd_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RECIR;
                    mode_fwd_q <= 1'b0;
                end
            endcase
        end
    end

    // Route tag pipeline shared by all lanes; captured from the pre-edge mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= mode_fwd_q;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        recir_lanes_lane #(
            .DATA_W     (DATA_W),
            .PIPE_DEPTH (PIPE_DEPTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .vld_i     (valid_in[i]),
            .dat_i     (data_in[i*DATA_W +: DATA_W]),
            .tag_i     (tag_q[PIPE_DEPTH-1]),
            .vld_fwd_o (valid_out[i]),
            .dat_fwd_o (data_out[i*DATA_W +: DATA_W]),
            .vld_ret_o (valid_ret[i]),
            .dat_ret_o (data_ret[i*DATA_W +: DATA_W])
        );
    end

`ifdef RECIR_CNT_EN
    // What the output stage is about to load: its tag and whether any lane is valid.
    logic ld_tag;
    logic ld_any;

    if (PIPE_DEPTH == 1) begin : g_ld1
        assign ld_tag = mode_fwd_q;
        assign ld_any = any_vld;
    end else begin : g_ldn
        logic [PIPE_DEPTH-2:0] vany_q;

        // Any-valid summary tracking the stages ahead of the output register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vany_q <= '0;
            end else begin
                vany_q[0] <= any_vld;
                for (int s = 1; s < PIPE_DEPTH-1; s++) begin
                    vany_q[s] <= vany_q[s-1];
                end
            end
        end

        assign ld_tag = tag_q[PIPE_DEPTH-2];
        assign ld_any = vany_q[PIPE_DEPTH-2];
    end

    logic [15:0] fwd_cnt_q;
    logic [15:0] ret_cnt_q;

    // Counters step as a transfer enters the output stage, so they always
    // include the transfer currently visible; they stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else if (ld_any) begin
            if (ld_tag && fwd_cnt_q != 16'hFFFF) fwd_cnt_q <= fwd_cnt_q + 16'd1;
            if (!ld_tag && ret_cnt_q != 16'hFFFF) ret_cnt_q <= ret_cnt_q + 16'd1;
        end
    end

    assign fwd_cnt = fwd_cnt_q;
    assign ret_cnt = ret_cnt_q;
`else
    assign fwd_cnt = 16'h0000;
    assign ret_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_recir_lanes.sv
// Bench for recir_lanes (LANES=4, DATA_W=32, PIPE_DEPTH=2): a queue-based
// model of captured words plus a two-flag mode model, compared every cycle,
// and directed literal checks that pin the model.
module tb_recir_lanes;
    localparam int LANES = 4;
    localparam int DATA_W = 32;
    localparam int PD = 2;
    localparam int W = LANES * DATA_W;

    logic           clk = 1'b0;
    logic           reset;
    logic           active;
    logic [3:0]     valid_in;
    logic [W-1:0]   data_in;
    logic [3:0]     valid_out, valid_ret;
    logic [W-1:0]   data_out, data_ret;
    logic           mode_fwd;
    logic [15:0]    fwd_cnt, ret_cnt;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 1'b0;

    recir_lanes #(.LANES(LANES), .DATA_W(DATA_W), .PIPE_DEPTH(PD)) dut (
        .clk(clk), .reset(reset), .active(active),
        .valid_in(valid_in), .data_in(data_in),
        .valid_out(valid_out), .data_out(data_out),
        .valid_ret(valid_ret), .data_ret(data_ret),
        .mode_fwd(mode_fwd), .fwd_cnt(fwd_cnt), .ret_cnt(ret_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic         tag;
        logic [3:0]   vld;
        logic [W-1:0] dat;
    } ent_t;

    ent_t m_q[$];
    bit   m_path;     // current path: 1 forward
    bit   m_pend;     // switch requested, waiting for an idle input cycle
    int   m_cf, m_cr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_path = 1'b0;
            m_pend = 1'b0;
            m_cf = 0;
            m_cr = 0;
        end else begin
            ent_t e;
            e.tag = m_path;
            e.vld = valid_in;
            e.dat = '0;
            for (int i = 0; i < LANES; i++)
                if (valid_in[i]) e.dat[i*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
            m_q.push_front(e);
            if (m_q.size() > PD) void'(m_q.pop_back());
            if (!m_pend) begin
                if (active != m_path) begin
                    if (valid_in != 0) m_pend = 1'b1;
                    else m_path = active;
                end
            end else begin
                if (active == m_path) m_pend = 1'b0;
                else if (valid_in == 0) begin
                    m_path = active;
                    m_pend = 1'b0;
                end
            end
            if (m_q.size() == PD && m_q[PD-1].vld != 0) begin
                if (m_q[PD-1].tag) begin if (m_cf < 65535) m_cf++; end
                else begin if (m_cr < 65535) m_cr++; end
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            logic [3:0]   evo, evr;
            logic [W-1:0] edo, edr;
            logic [15:0]  ecf, ecr;
            evo = '0; evr = '0; edo = '0; edr = '0;
            if (m_q.size() == PD) begin
                if (m_q[PD-1].tag) begin evo = m_q[PD-1].vld; edo = m_q[PD-1].dat; end
                else begin evr = m_q[PD-1].vld; edr = m_q[PD-1].dat; end
            end
`ifdef RECIR_CNT_EN
            ecf = 16'(m_cf);
            ecr = 16'(m_cr);
`else
            ecf = 16'h0;
            ecr = 16'h0;
`endif
            check("cmp_valid_out", W'(valid_out), W'(evo));
            check("cmp_data_out", data_out, edo);
            check("cmp_valid_ret", W'(valid_ret), W'(evr));
            check("cmp_data_ret", data_ret, edr);
            check("cmp_mode_fwd", W'(mode_fwd), W'(m_path));
            check("cmp_fwd_cnt", W'(fwd_cnt), W'(ecf));
            check("cmp_ret_cnt", W'(ret_cnt), W'(ecr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic a, input logic [3:0] v, input logic [W-1:0] d);
        active = a;
        valid_in = v;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = $urandom;
        return d;
    endfunction

    function automatic logic [W-1:0] t2_data();
        logic [W-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = 32'h0000ABCD * 32'(i + 1);
        return d;
    endfunction

    function automatic logic [W-1:0] tag_data(input int c);
        logic [W-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = {16'(16'hC300 + c), 16'(i)};
        return d;
    endfunction

    initial begin
        logic [W-1:0] d;
        reset = 1'b1;
        active = 1'b0;
        valid_in = '0;
        data_in = '0;
        run_cmp = 1'b1;

        // 1. Reset with random inputs
        for (int c = 0; c < 3; c++) begin
            active = 1'($urandom);
            valid_in = 4'($urandom);
            data_in = rnd_data();
            @(posedge clk);
            #1;
            check("rst_valid_out", W'(valid_out), '0);
            check("rst_valid_ret", W'(valid_ret), '0);
            check("rst_data", data_out | data_ret, '0);
            check("rst_mode_fwd", W'(mode_fwd), '0);
        end
        active = 1'b0;
        valid_in = '0;
        reset = 1'b0;
        drive(0, 4'b0000, '0);

        // 2. Recirculate four full-lane words
        for (int c = 0; c < 4; c++) drive(0, 4'b1111, t2_data());
        drive(0, 4'b0000, '0);
        check("t2_data_ret_l1", W'(data_ret[63:32]), W'(32'h0001579A));
        check("t2_data_ret_l3", W'(data_ret[127:96]), W'(32'h0002AF34));
        check("t2_valid_ret", W'(valid_ret), W'(4'b1111));
        check("t2_valid_out", W'(valid_out), '0);
`ifdef RECIR_CNT_EN
        check("t2_ret_cnt", W'(ret_cnt), W'(16'd4));
`else
        check("t2_ret_cnt_off", W'(ret_cnt), '0);
`endif
        drive(0, 4'b0000, '0);

        // 3. Boundary switch
        for (int c = 0; c < 5; c++) begin
            drive(c >= 2, 4'b0101, tag_data(c));
            if (c == 2) check("t3_pending_mode", W'(mode_fwd), '0);
        end
        drive(1, 4'b0000, tag_data(5));
        check("t3_mode_after_idle", W'(mode_fwd), W'(1'b1));
        check("t3_c4_on_ret", W'(valid_ret), W'(4'b0101));
        check("t3_c4_ret_data", data_ret, {32'h0, 32'hC3040002, 32'h0, 32'hC3040000});
        drive(1, 4'b0101, tag_data(6));
        drive(1, 4'b0101, tag_data(7));
        check("t3_c6_on_fwd", W'(valid_out), W'(4'b0101));
        check("t3_c6_ret_zero", W'(valid_ret), '0);

        // back to RECIR through an idle cycle
        drive(0, 4'b0000, '0);
        drive(0, 4'b0000, '0);
        check("t3_back_recir", W'(mode_fwd), '0);

        // 4. Idle switch
        drive(1, 4'b0000, '0);
        check("t4_mode_fwd", W'(mode_fwd), W'(1'b1));
        d = '0;
        d[127:96] = 32'h0000EFAB;
        drive(1, 4'b1000, d);
        drive(1, 4'b0000, '0);
        check("t4_data_out_l3", W'(data_out[127:96]), W'(32'h0000EFAB));
        check("t4_valid_out", W'(valid_out), W'(4'b1000));
        check("t4_data_ret", data_ret, '0);

        // 5. Abort pending switch while traffic continues
        drive(1, 4'b1111, rnd_data());
        drive(0, 4'b1111, rnd_data());
        check("t5_pending_mode", W'(mode_fwd), W'(1'b1));
        drive(1, 4'b1111, rnd_data());
        drive(1, 4'b1111, rnd_data());
        check("t5_mode_fwd", W'(mode_fwd), W'(1'b1));
        check("t5_valid_out", W'(valid_out), W'(4'b1111));
        check("t5_valid_ret", W'(valid_ret), '0);

        // active toggling every cycle under continuous traffic
        for (int c = 0; c < 10; c++) drive(c[0], 4'($urandom_range(1, 15)), rnd_data());
        drive(1, 4'b0000, '0);

        // mixed random traffic, model-checked
        for (int c = 0; c < 60; c++) drive(1'($urandom), 4'($urandom), rnd_data());

        // asynchronous reset mid-cycle during forward traffic
        drive(1, 4'b0000, '0);
        drive(1, 4'b0000, '0);
        drive(1, 4'b1111, rnd_data());
        drive(1, 4'b1111, rnd_data());
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid_out", W'(valid_out), '0);
        check("arst_data_out", data_out, '0);
        check("arst_mode_fwd", W'(mode_fwd), '0);
        check("arst_cnt", W'({fwd_cnt, ret_cnt}), '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 4'b0011, rnd_data());
        drive(0, 4'b0000, '0);
        check("post_rst_ret", W'(valid_ret), W'(4'b0011));

        // 6. Counter saturation / disabled counters
`ifdef RECIR_CNT_EN
        drive(1, 4'b0000, '0);
        for (int c = 0; c < 70000; c++) drive(1, 4'b0001, rnd_data());
        drive(1, 4'b0000, '0);
        check("t6_fwd_sat", W'(fwd_cnt), W'(16'hFFFF));
        check("t6_ret_cnt", W'(ret_cnt), W'(16'd1));
`else
        for (int c = 0; c < 20; c++) drive(1, 4'b1111, rnd_data());
        drive(1, 4'b0000, '0);
        check("t6_cnt_off", W'({fwd_cnt, ret_cnt}), '0);
`endif
        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
